edge_event_arbiter: RTL and testbench
=====================================

# edge_event_arbiter

Collects 1-cycle rise/fall pulses from up to N_CH edge-detector channels and queues them per channel. It round-robin arbitrates the queued events onto a single valid/ready event stream tagged with channel ID and edge type. It sits downstream of the per-signal edge highlighters and feeds the event consumer (interrupt/logging logic). It owns event ordering, back-pressure, overflow reporting and flush.

## Interface
- N_CH, 4, number of edge channels (2..16).
- ID_W, $clog2(N_CH), width of channel ID. Derived; not overridden.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- rise_in  input  N_CH  per-channel 1-cycle rising-edge pulses, synchronous to clk.
- fall_in  input  N_CH  per-channel 1-cycle falling-edge pulses, synchronous to clk.
- en  input  1  1 = arbiter may load new events into the output stage; 0 = hold, capture continues.
- flush  input  1  synchronous clear of all queues and the output stage.
- ovf_clr  input  N_CH  write-one-clear for the ovf bits.
- evt_valid  output  1  output event valid.
- evt_ready  input  1  consumer accepts the event when evt_valid && evt_ready.
- evt_ch  output  ID_W  channel of the output event.
- evt_rise  output  1  1 = rising edge, 0 = falling edge.
- pend  output  N_CH  per channel: queue count != 0.
- ovf  output  N_CH  sticky per channel: an event was dropped.

## Operation
- Per channel: a 2-entry FIFO of edge-type bits, with count 0..2, head pointer and tail pointer.
- Push:
  - A rise_in bit enqueues 1. A fall_in bit enqueues 0.
  - If both bits assert on the same channel in the same cycle, enqueue rise first, then fall.
- Capacity: free space = 2 − count + (1 if that channel is popped this cycle). A pop frees its slot in the same cycle.
- Overflow:
  - Any push that exceeds free space is dropped and sets ovf[ch].
  - With both pulses asserted and only 1 free slot, rise is kept and fall is dropped.
- ovf_clr[ch] clears ovf[ch]. A set in the same cycle has priority over the clear.
- Output stage is a single register holding evt_valid, evt_ch and evt_rise.
  - It is loadable when en=1 and (evt_valid=0 or evt_ready=1).
  - When loadable and any channel has count != 0, load the winner's head entry and pop that channel.
  - When loadable and no channel has a queued event, evt_valid goes to 0.
  - When en=0 the stage still completes a handshake (evt_valid drops after acceptance) but loads nothing new.
- Round-robin:
  - The search starts at last_grant+1 mod N_CH.
  - last_grant updates to the winner on each load only.
  - Reset value of last_grant is N_CH−1, so ch0 has first priority.
- Within a channel, events leave in arrival order.
- flush:
  - Sets every count to 0 and evt_valid to 0. ovf and last_grant are unchanged.
  - Pushes arriving in the flush cycle are discarded and do not set ovf.

## Timing
- Reset (rst=1) forces the following, asynchronously: all counts 0, evt_valid 0, evt_ch 0, evt_rise 0, pend 0, ovf 0, last_grant N_CH−1.
- Latency: pulse high in cycle n → FIFO updated at the edge ending n → output stage loaded at the next edge → evt_valid=1 in cycle n+2. There is no bypass.
- Throughput: 1 event/cycle while evt_ready=1 and events are queued.
- Hold: while evt_valid=1 and evt_ready=0, evt_ch and evt_rise are stable. The output stage is not reloaded.
- pend reflects the registered count, so it rises in cycle n+1 after a pulse in cycle n.
- Priority at one edge: rst > flush > normal push/pop.
- Reset asserted mid-handshake drops the pending event. No partial state survives.

## Test plan
- Single event:
  - Stimulus: rise_in[2]=1 in cycle 0, evt_ready=1, en=1.
  - Response: evt_valid=1, evt_ch=2, evt_rise=1 in cycle 2 only. pend[2]=1 in cycle 1 only.
- Round-robin:
  - Stimulus: rise_in=4'b1111 in cycle 0, evt_ready=1.
  - Response: evt_ch = 0, 1, 2, 3 in cycles 2..5.
  - Then rise_in[3] and rise_in[0] together in cycle 10 → ch0 then ch3.
- Back-pressure and ordering:
  - Stimulus: evt_ready=0, fall_in[1] in cycle 0, rise_in[1] in cycle 1.
  - Response: evt_valid holds ch1/fall stable. After evt_ready=1, the next event is ch1/rise. ovf[1]=0.
- Overflow:
  - Stimulus: evt_ready=0, en=0; 3 pulses on ch0 in cycles 0, 2, 4.
  - Response: ovf[0]=1 from cycle 5, count=2, the third event is lost.
  - ovf_clr[0]=1 coinciding with a fourth pulse → ovf[0] stays 1. ovf_clr alone → 0.
- Simultaneous rise+fall:
  - Stimulus: rise_in[0]=fall_in[0]=1 in one cycle on an empty queue.
  - Response: rise then fall delivered. On a queue with count=1, fall is dropped and ovf[0]=1.
- Flush and reset:
  - Stimulus: queue 3 events, assert flush for 1 cycle.
  - Response: evt_valid=0 and pend=0 next cycle, with no further events.
  - Assert rst asynchronously while evt_valid=1 → evt_valid=0 immediately. After release, ch0 has first priority.

Source files
------------

// File: rtl/edge_event_arbiter.sv
// rtl/edge_event_arbiter.sv - per-channel edge event queues with round-robin output stage
//
// Purpose:
//   Captures 1-cycle rise/fall pulses from N_CH edge channels into a 2-entry
//   FIFO per channel. Queued events are round-robin arbitrated onto a single
//   valid/ready event stream, tagged with channel ID and edge type.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   rise_in    per-channel rising-edge pulses
//   fall_in    per-channel falling-edge pulses
//   en         1 = output stage may load new events
//   flush      synchronous clear of all queues and the output stage
//   ovf_clr    write-one-clear of the sticky overflow bits
//   evt_valid  output event valid
//   evt_ready  consumer accepts when evt_valid && evt_ready
//   evt_ch     channel of the output event
//   evt_rise   1 = rising edge, 0 = falling edge
//   pend       per channel: queue not empty (registered count)
//   ovf        per channel: sticky, an event was dropped
module edge_event_arbiter #(
  parameter int N_CH = 4,
  localparam int ID_W = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] rise_in,
  input  logic [N_CH-1:0] fall_in,
  input  logic            en,
  input  logic            flush,
  input  logic [N_CH-1:0] ovf_clr,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [ID_W-1:0] evt_ch,
  output logic            evt_rise,
  output logic [N_CH-1:0] pend,
  output logic [N_CH-1:0] ovf
);

  // Per-channel FIFO state: two edge-type bits, count 0..2, head/tail index.
  logic [N_CH-1:0][1:0] fifo_q, fifo_d;
  logic [N_CH-1:0][1:0] cnt_q, cnt_d;
  logic [N_CH-1:0]      head_q, head_d;
  logic [N_CH-1:0]      tail_q, tail_d;
  logic [N_CH-1:0]      ovf_q, ovf_d;
  logic [ID_W-1:0]      last_grant_q, last_grant_d;

  logic                 evt_valid_q, evt_valid_d;
  logic [ID_W-1:0]      evt_ch_q, evt_ch_d;
  logic                 evt_rise_q, evt_rise_d;

  logic                 loadable;
  logic                 any_pend;
  logic [ID_W-1:0]      winner;
  logic [N_CH-1:0]      pop;
  logic [N_CH-1:0]      keep_r, keep_f;
  logic [N_CH-1:0]      ovf_set;

  // The output register may take a new event when it is empty or its
  // current event is being accepted this cycle.
  assign loadable = en && (!evt_valid_q || evt_ready);

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    logic [ID_W-1:0] idx;
    any_pend = 1'b0;
    winner   = '0;
    idx      = '0;
    for (int i = 0; i < N_CH; i++) begin
      idx = ID_W'((int'(last_grant_q) + 1 + i) % N_CH);
      if (!any_pend && (cnt_q[idx] != 2'd0)) begin
        any_pend = 1'b1;
        winner   = idx;
      end
    end
  end

  always_comb begin
    pop = '0;
    if (loadable && any_pend && !flush) begin
      pop[winner] = 1'b1;
    end
  end

  // Push acceptance. A pop in the same cycle frees its slot, so a full
  // queue being drained can still take one new event. Rise is placed
  // ahead of fall when both arrive together.
  always_comb begin
    int free_slots;
    free_slots = 0;
    keep_r     = '0;
    keep_f     = '0;
    ovf_set    = '0;
    fifo_d     = fifo_q;
    cnt_d      = cnt_q;
    head_d     = head_q;
    tail_d     = tail_q;
    for (int ch = 0; ch < N_CH; ch++) begin
      free_slots = 2 - int'(cnt_q[ch]) + int'(pop[ch]);
      keep_r[ch] = rise_in[ch] && (free_slots >= 1);
      keep_f[ch] = fall_in[ch] && (free_slots >= (keep_r[ch] ? 2 : 1));
      ovf_set[ch] = (rise_in[ch] && !keep_r[ch]) || (fall_in[ch] && !keep_f[ch]);
      if (keep_r[ch]) begin
        fifo_d[ch][tail_q[ch]] = 1'b1;
      end
      if (keep_f[ch]) begin
        fifo_d[ch][tail_q[ch] ^ keep_r[ch]] = 1'b0;
      end
      tail_d[ch] = tail_q[ch] ^ (keep_r[ch] ^ keep_f[ch]);
      head_d[ch] = head_q[ch] ^ pop[ch];
      cnt_d[ch]  = cnt_q[ch] - {1'b0, pop[ch]} + {1'b0, keep_r[ch]} + {1'b0, keep_f[ch]};
    end
    // Flush discards everything in flight, including this cycle's pushes,
    // and those discarded pushes are not overflows.
    if (flush) begin
      cnt_d   = '0;
      head_d  = '0;
      tail_d  = '0;
      ovf_set = '0;
    end
  end

  // Set wins over a simultaneous clear.
  assign ovf_d = (ovf_q & ~ovf_clr) | ovf_set;

  always_comb begin
    evt_valid_d  = evt_valid_q;
    evt_ch_d     = evt_ch_q;
    evt_rise_d   = evt_rise_q;
    last_grant_d = last_grant_q;
    if (flush) begin
      evt_valid_d = 1'b0;
    end else if (loadable) begin
      if (any_pend) begin
        evt_valid_d  = 1'b1;
        evt_ch_d     = winner;
        evt_rise_d   = fifo_q[winner][head_q[winner]];
        last_grant_d = winner;
      end else begin
        evt_valid_d = 1'b0;
      end
    end else if (evt_valid_q && evt_ready) begin
      // en=0: finish the handshake but do not reload.
      evt_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_q       <= '0;
      cnt_q        <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      ovf_q        <= '0;
      last_grant_q <= ID_W'(N_CH - 1);
      evt_valid_q  <= 1'b0;
      evt_ch_q     <= '0;
      evt_rise_q   <= 1'b0;
    end else begin
      fifo_q       <= fifo_d;
      cnt_q        <= cnt_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      ovf_q        <= ovf_d;
      last_grant_q <= last_grant_d;
      evt_valid_q  <= evt_valid_d;
      evt_ch_q     <= evt_ch_d;
      evt_rise_q   <= evt_rise_d;
    end
  end

  always_comb begin
    pend = '0;
    for (int ch = 0; ch < N_CH; ch++) begin
      pend[ch] = (cnt_q[ch] != 2'd0);
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_ch    = evt_ch_q;
  assign evt_rise  = evt_rise_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb/tb_edge_event_arbiter.sv - directed self-checking bench for edge_event_arbiter
module tb_edge_event_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] rise_in, fall_in, ovf_clr, pend, ovf;
  logic       en, flush, evt_valid, evt_ready, evt_rise;
  logic [1:0] evt_ch;

  int checks   = 0;
  int failures = 0;

  edge_event_arbiter #(.N_CH(4)) dut (
    .clk(clk), .rst(rst), .rise_in(rise_in), .fall_in(fall_in), .en(en),
    .flush(flush), .ovf_clr(ovf_clr), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_ch(evt_ch), .evt_rise(evt_rise), .pend(pend), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Advance to 1 ns after the next rising edge: inputs for the new cycle
  // are driven and that cycle's outputs are sampled from here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; rise_in = '0; fall_in = '0; ovf_clr = '0;
    en = 1'b1; flush = 1'b0; evt_ready = 1'b1;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", evt_valid); end
    checks++; if (evt_ch !== 2'd0) begin failures++; $display("FAIL reset_ch got=%0d exp=0", evt_ch); end
    checks++; if (evt_rise !== 1'b0) begin failures++; $display("FAIL reset_rise got=%0b exp=0", evt_rise); end
    checks++; if (pend !== 4'b0000) begin failures++; $display("FAIL reset_pend got=%b exp=0000", pend); end
    checks++; if (ovf !== 4'b0000) begin failures++; $display("FAIL reset_ovf got=%b exp=0000", ovf); end
  endtask

  task automatic test_single();
    do_reset();
    rise_in = 4'b0100;                                  // cycle 0
    step(); rise_in = '0;                               // cycle 1
    checks++; if (pend !== 4'b0100) begin failures++; $display("FAIL single_pend1 got=%b exp=0100", pend); end
    checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL single_valid1 got=%0b exp=0", evt_valid); end
    step();                                             // cycle 2
    checks++; if ({evt_valid, evt_ch, evt_rise} !== {1'b1, 2'd2, 1'b1}) begin failures++; $display("FAIL single_evt got=%b%b%b exp=1101", evt_valid, evt_ch, evt_rise); end
    checks++; if (pend !== 4'b0000) begin failures++; $display("FAIL single_pend2 got=%b exp=0000", pend); end
    step();                                             // cycle 3
    checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL single_valid3 got=%0b exp=0", evt_valid); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_ch [4];
    exp_ch = '{2'd0, 2'd1, 2'd2, 2'd3};
    do_reset();
    rise_in = 4'b1111;                                  // cycle 0
    step(); rise_in = '0;                               // cycle 1
    checks++; if (pend !== 4'b1111) begin failures++; $display("FAIL rr_pend got=%b exp=1111", pend); end
    for (int i = 0; i < 4; i++) begin
      step();                                           // cycles 2..5
      checks++; if ({evt_valid, evt_ch} !== {1'b1, exp_ch[i]}) begin failures++; $display("FAIL rr_evt%0d got=v%0b ch%0d exp=v1 ch%0d", i, evt_valid, evt_ch, exp_ch[i]); end
    end
    step();                                             // cycle 6
    checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL rr_idle got=%0b exp=0", evt_valid); end
    repeat (4) step();                                  // cycle 10
    rise_in = 4'b1001;
    step(); rise_in = '0;                               // cycle 11
    step();                                             // cycle 12
    checks++; if ({evt_valid, evt_ch} !== {1'b1, 2'd0}) begin failures++; $display("FAIL rr_wrap0 got=v%0b ch%0d exp=v1 ch0", evt_valid, evt_ch); end
    step();                                             // cycle 13
    checks++; if ({evt_valid, evt_ch} !== {1'b1, 2'd3}) begin failures++; $display("FAIL rr_wrap3 got=v%0b ch%0d exp=v1 ch3", evt_valid, evt_ch); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    evt_ready = 1'b0;
    fall_in = 4'b0010;                                  // cycle 0
    step(); fall_in = '0; rise_in = 4'b0010;            // cycle 1
    step(); rise_in = '0;                               // cycle 2
    for (int i = 0; i < 3; i++) begin                   // cycles 2..4 held
      checks++; if ({evt_valid, evt_ch, evt_rise} !== {1'b1, 2'd1, 1'b0}) begin failures++; $display("FAIL bp_hold%0d got=%b%b%b exp=1010", i, evt_valid, evt_ch, evt_rise); end
      if (i < 2) step();
    end
    checks++; if (pend !== 4'b0010) begin failures++; $display("FAIL bp_pend got=%b exp=0010", pend); end
    evt_ready = 1'b1;
    step();                                             // cycle 5
    checks++; if ({evt_valid, evt_ch, evt_rise} !== {1'b1, 2'd1, 1'b1}) begin failures++; $display("FAIL bp_next got=%b%b%b exp=1011", evt_valid, evt_ch, evt_rise); end
    step();                                             // cycle 6
    checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL bp_done got=%0b exp=0", evt_valid); end
    checks++; if (ovf !== 4'b0000) begin failures++; $display("FAIL bp_ovf got=%b exp=0000", ovf); end
  endtask

  task automatic test_overflow();
    do_reset();
    evt_ready = 1'b0; en = 1'b0;
    rise_in = 4'b0001;                                  // cycle 0
    step(); rise_in = '0;
    step(); fall_in = 4'b0001;                          // cycle 2
    step(); fall_in = '0;                               // cycle 3
    checks++; if (ovf !== 4'b0000) begin failures++; $display("FAIL ovf_early got=%b exp=0000", ovf); end
    step(); rise_in = 4'b0001;                          // cycle 4: third pulse, dropped
    step(); rise_in = '0;                               // cycle 5
    checks++; if (ovf !== 4'b0001) begin failures++; $display("FAIL ovf_set got=%b exp=0001", ovf); end
    checks++; if (pend !== 4'b0001) begin failures++; $display("FAIL ovf_pend got=%b exp=0001", pend); end
    step(); ovf_clr = 4'b0001; fall_in = 4'b0001;       // cycle 6: clear vs new drop
    step(); fall_in = '0;                               // cycle 7: clear alone
    checks++; if (ovf !== 4'b0001) begin failures++; $display("FAIL ovf_setwins got=%b exp=0001", ovf); end
    step(); ovf_clr = '0;                               // cycle 8
    checks++; if (ovf !== 4'b0000) begin failures++; $display("FAIL ovf_clr got=%b exp=0000", ovf); end
    en = 1'b1; evt_ready = 1'b1;
    step();                                             // cycle 9
    checks++; if ({evt_valid, evt_ch, evt_rise} !== {1'b1, 2'd0, 1'b1}) begin failures++; $display("FAIL ovf_first got=%b%b%b exp=1001", evt_valid, evt_ch, evt_rise); end
    step();                                             // cycle 10
    checks++; if ({evt_valid, evt_ch, evt_rise} !== {1'b1, 2'd0, 1'b0}) begin failures++; $display("FAIL ovf_second got=%b%b%b exp=1000", evt_valid, evt_ch, evt_rise); end
    step();                                             // cycle 11
    checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL ovf_lost got=%0b exp=0", evt_valid); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    rise_in = 4'b0001; fall_in = 4'b0001;               // cycle 0, empty queue
    step(); rise_in = '0; fall_in = '0;
    step();                                             // cycle 2
    checks++; if ({evt_valid, evt_ch, evt_rise} !== {1'b1, 2'd0, 1'b1}) begin failures++; $display("FAIL sim_rise got=%b%b%b exp=1001", evt_valid, evt_ch, evt_rise); end
    step();                                             // cycle 3
    checks++; if ({evt_valid, evt_ch, evt_rise} !== {1'b1, 2'd0, 1'b0}) begin failures++; $display("FAIL sim_fall got=%b%b%b exp=1000", evt_valid, evt_ch, evt_rise); end
    step();                                             // cycle 4
    checks++; if ({evt_valid, ovf} !== {1'b0, 4'b0000}) begin failures++; $display("FAIL sim_done got=v%0b ovf%b exp=v0 ovf0000", evt_valid, ovf); end
    en = 1'b0; evt_ready = 1'b0;
    rise_in = 4'b0001;                                  // count becomes 1
    step(); fall_in = 4'b0001;                          // both with one free slot
    step(); rise_in = '0; fall_in = '0;
    checks++; if ({ovf, pend} !== {4'b0001, 4'b0001}) begin failures++; $display("FAIL sim_drop got=ovf%b pend%b exp=ovf0001 pend0001", ovf, pend); end
    en = 1'b1; evt_ready = 1'b1;
    step();
    checks++; if ({evt_valid, evt_rise} !== 2'b11) begin failures++; $display("FAIL sim_keep1 got=v%0b r%0b exp=v1 r1", evt_valid, evt_rise); end
    step();
    checks++; if ({evt_valid, evt_rise} !== 2'b11) begin failures++; $display("FAIL sim_keep2 got=v%0b r%0b exp=v1 r1", evt_valid, evt_rise); end
    step();
    checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL sim_empty got=%0b exp=0", evt_valid); end
  endtask

  task automatic test_flush();
    do_reset();
    evt_ready = 1'b0;
    rise_in = 4'b0111;                                  // cycle 0
    step(); rise_in = '0;                               // cycle 1
    step();                                             // cycle 2
    checks++; if ({evt_valid, evt_ch, pend} !== {1'b1, 2'd0, 4'b0110}) begin failures++; $display("FAIL fl_pre got=v%0b ch%0d pend%b exp=v1 ch0 pend0110", evt_valid, evt_ch, pend); end
    flush = 1'b1; rise_in = 4'b1000;                    // push in flush cycle is discarded
    step(); flush = 1'b0; rise_in = '0; evt_ready = 1'b1;
    checks++; if ({evt_valid, pend, ovf} !== {1'b0, 4'b0000, 4'b0000}) begin failures++; $display("FAIL fl_clear got=v%0b pend%b ovf%b exp=v0 pend0000 ovf0000", evt_valid, pend, ovf); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL fl_quiet%0d got=%0b exp=0", i, evt_valid); end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    evt_ready = 1'b0;
    rise_in = 4'b0010;
    step(); rise_in = '0;
    step();
    checks++; if ({evt_valid, evt_ch} !== {1'b1, 2'd1}) begin failures++; $display("FAIL ar_pre got=v%0b ch%0d exp=v1 ch1", evt_valid, evt_ch); end
    #2 rst = 1'b1;                                      // mid-cycle
    #1;
    checks++; if ({evt_valid, evt_ch, pend} !== {1'b0, 2'd0, 4'b0000}) begin failures++; $display("FAIL ar_now got=v%0b ch%0d pend%b exp=v0 ch0 pend0000", evt_valid, evt_ch, pend); end
    step(); #2 rst = 1'b0;
    step(); evt_ready = 1'b1; rise_in = 4'b1001;
    step(); rise_in = '0;
    step();
    checks++; if ({evt_valid, evt_ch} !== {1'b1, 2'd0}) begin failures++; $display("FAIL ar_prio0 got=v%0b ch%0d exp=v1 ch0", evt_valid, evt_ch); end
    step();
    checks++; if ({evt_valid, evt_ch} !== {1'b1, 2'd3}) begin failures++; $display("FAIL ar_prio3 got=v%0b ch%0d exp=v1 ch3", evt_valid, evt_ch); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_overflow();
    test_simultaneous();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
